// File: rtl/operand_access_pkg.sv
// Shared types for the 6502 operand-access stage: opcode classes, FSM states, opcode field slices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package operand_access_pkg;

  // Default widths used by the top-level parameters
  localparam int OA_REG_WIDTH  = 8;
  localparam int OA_ADDR_WIDTH = 16;

  // Opcode field slice positions: aaa=[7:5], bbb=[4:2], cc=[1:0]
  localparam int AAA_MSB = 7;
  localparam int AAA_LSB = 5;
  localparam int BBB_MSB = 4;
  localparam int BBB_LSB = 2;
  localparam int CC_MSB  = 1;
  localparam int CC_LSB  = 0;

  typedef enum logic [2:0] {
    CLS_IMM   = 3'd0,
    CLS_IMPL  = 3'd1,
    CLS_READ  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_RMW   = 3'd4
  } op_class_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_RDATA   = 3'd2,
    ST_OPERAND = 3'd3,
    ST_EXEC    = 3'd4,
    ST_WRITE   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // True when the addressing mode named by bbb/cc touches memory.
  // cc=01: everything except bbb=010 (#imm).
  // cc=00/10: zpg, abs, zpg-indexed, abs-indexed (odd bbb); the even
  // codes are immediate, accumulator, implied or branch.
  function automatic logic is_mem_mode(input logic [2:0] bbb, input logic [1:0] cc);
    if (cc == 2'b01) begin
      return (bbb != 3'b010);
    end
    return bbb[0];
  endfunction

endpackage

// File: rtl/operand_access_opclass_decode.sv
// Opcode classifier: maps a 6502 opcode to IMM / IMPL / STORE / RMW / READ.
// Latency: purely combinational.
// Backpressure: none.
module opclass_decode
  import operand_access_pkg::*;
(
  input  logic [7:0] opcode,
  output op_class_t  op_class
);

  logic [2:0] aaa;
  logic [2:0] bbb;
  logic [1:0] cc;

  assign aaa = opcode[AAA_MSB:AAA_LSB];
  assign bbb = opcode[BBB_MSB:BBB_LSB];
  assign cc  = opcode[CC_MSB:CC_LSB];

  // Priority classification: immediates/branches, then implied, then store, RMW, read
  always_comb begin
    logic is_imm;
    logic is_impl;
    is_imm  = 1'b0;
    is_impl = 1'b0;

    case (opcode)
      8'hA9, 8'hA2, 8'hA0, 8'hC0, 8'hE0: is_imm = 1'b1;
      default: ;
    endcase
    if (bbb == 3'b100 && cc == 2'b00) begin
      is_imm = 1'b1;
    end

    case (opcode)
      8'h0A, 8'h8A, 8'h9A, 8'hBA, 8'h00,
      8'h20, 8'h40, 8'h60, 8'h4C, 8'h6C: is_impl = 1'b1;
      default: ;
    endcase
    if (cc == 2'b00 && (bbb == 3'b010 || bbb == 3'b110)) begin
      is_impl = 1'b1;
    end

    if (is_imm) begin
      op_class = CLS_IMM;
    end else if (is_impl) begin
      op_class = CLS_IMPL;
    end else if (aaa == 3'b100 && is_mem_mode(bbb, cc)) begin
      op_class = CLS_STORE;
    end else if (cc == 2'b10 && aaa != 3'b100 && aaa != 3'b101 && is_mem_mode(bbb, cc)) begin
      op_class = CLS_RMW;
    end else begin
      op_class = CLS_READ;
    end
  end

endmodule

// File: rtl/operand_access.sv
// 6502 operand-phase access: fetch operand (read), hand to ALU, write back (store/RMW), pulse done.
// Latency: read class operand 3 cycles after launch, others 1; done 1 cycle after alu_valid (2 with a write).
// Backpressure: waits in EXEC for alu_valid; launches ignored while busy. Macro RMW_DUMMY_WRITE_EN adds the RMW dummy write.
module operand_access
  import operand_access_pkg::*;
#(
  parameter int REG_WIDTH  = OA_REG_WIDTH,
  parameter int ADDR_WIDTH = OA_ADDR_WIDTH
) (
  input  logic                  phi1,
  input  logic                  reset,
  input  logic                  instruction_ready,
  input  logic [REG_WIDTH-1:0]  instruction_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [REG_WIDTH-1:0]  imm_in,
  input  logic [REG_WIDTH-1:0]  mem_data_in,
  input  logic [REG_WIDTH-1:0]  alu_result,
  input  logic                  alu_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [REG_WIDTH-1:0]  mem_data_out,
  output logic [REG_WIDTH-1:0]  operand,
  output logic                  operand_valid,
  output logic [REG_WIDTH-1:0]  opcode_out,
  output logic                  instruction_done,
  output logic                  busy
);

  state_t    state;
  state_t    state_nxt;
  op_class_t cls_dec;
  op_class_t cls_q;
  op_class_t cls_nxt;

  logic                  ready_d;
  logic                  launch;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [REG_WIDTH-1:0]  result_q;
  logic [REG_WIDTH-1:0]  result_nxt;
  logic                  second_wr_q;
  logic                  second_wr_nxt;

  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic                  mem_rd_nxt;
  logic                  mem_wr_nxt;
  logic [REG_WIDTH-1:0]  mem_data_out_nxt;
  logic [REG_WIDTH-1:0]  operand_nxt;
  logic                  operand_valid_nxt;
  logic [REG_WIDTH-1:0]  opcode_nxt;
  logic                  done_nxt;
  logic                  busy_nxt;

  // Only a rising edge of the level launches; ready_d resets high so a held level cannot
  assign launch = instruction_ready && !ready_d;

  opclass_decode u_opclass_decode (
    .opcode   (instruction_in[7:0]),
    .op_class (cls_dec)
  );

  // State register
  always_ff @(posedge phi1) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (launch) begin
          if (cls_dec == CLS_READ || cls_dec == CLS_RMW) begin
            state_nxt = ST_READ;
          end else begin
            state_nxt = ST_OPERAND;
          end
        end
      end
      ST_READ:    state_nxt = ST_RDATA;
      ST_RDATA:   state_nxt = ST_OPERAND;
      ST_OPERAND: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (alu_valid) begin
          if (cls_q == CLS_STORE || cls_q == CLS_RMW) begin
            state_nxt = ST_WRITE;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      // A pending second write keeps us here for one more cycle
      ST_WRITE:   state_nxt = second_wr_q ? ST_WRITE : ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values; strobes are decoded from the state being entered so they register in step with it
  always_comb begin
    opcode_nxt        = opcode_out;
    addr_nxt          = addr_q;
    cls_nxt           = cls_q;
    operand_nxt       = operand;
    result_nxt        = result_q;
    second_wr_nxt     = 1'b0;
    mem_addr_nxt      = '0;
    mem_data_out_nxt  = '0;

    case (state)
      ST_IDLE: begin
        if (launch) begin
          opcode_nxt = instruction_in;
          addr_nxt   = addr_in;
          cls_nxt    = cls_dec;
          if (cls_dec == CLS_IMM || cls_dec == CLS_IMPL) begin
            operand_nxt = imm_in;
          end else if (cls_dec == CLS_STORE) begin
            operand_nxt = '0;
          end
        end
      end
      ST_RDATA: operand_nxt = mem_data_in;
      ST_EXEC: begin
        if (alu_valid) begin
          result_nxt       = alu_result;
          mem_data_out_nxt = alu_result;
`ifdef RMW_DUMMY_WRITE_EN
          // RMW writes the unmodified operand first, the result on the following cycle
          if (cls_q == CLS_RMW) begin
            mem_data_out_nxt = operand;
            second_wr_nxt    = 1'b1;
          end
`endif
        end
      end
      ST_WRITE: begin
        if (second_wr_q) begin
          mem_data_out_nxt = result_q;
        end
      end
      default: ;
    endcase

    mem_rd_nxt        = (state_nxt == ST_READ);
    mem_wr_nxt        = (state_nxt == ST_WRITE);
    operand_valid_nxt = (state_nxt == ST_OPERAND);
    done_nxt          = (state_nxt == ST_DONE);
    busy_nxt          = (state_nxt != ST_IDLE);

    if (mem_rd_nxt || mem_wr_nxt) begin
      mem_addr_nxt = addr_nxt;
    end
    if (!mem_wr_nxt) begin
      mem_data_out_nxt = '0;
    end
  end

  // Registered outputs and latched instruction context
  always_ff @(posedge phi1) begin
    ready_d <= reset ? 1'b1 : instruction_ready;
    if (reset) begin
      opcode_out       <= '0;
      addr_q           <= '0;
      cls_q            <= CLS_IMM;
      operand          <= '0;
      result_q         <= '0;
      second_wr_q      <= 1'b0;
      mem_addr         <= '0;
      mem_rd           <= 1'b0;
      mem_wr           <= 1'b0;
      mem_data_out     <= '0;
      operand_valid    <= 1'b0;
      instruction_done <= 1'b0;
      busy             <= 1'b0;
    end else begin
      opcode_out       <= opcode_nxt;
      addr_q           <= addr_nxt;
      cls_q            <= cls_nxt;
      operand          <= operand_nxt;
      result_q         <= result_nxt;
      second_wr_q      <= second_wr_nxt;
      mem_addr         <= mem_addr_nxt;
      mem_rd           <= mem_rd_nxt;
      mem_wr           <= mem_wr_nxt;
      mem_data_out     <= mem_data_out_nxt;
      operand_valid    <= operand_valid_nxt;
      instruction_done <= done_nxt;
      busy             <= busy_nxt;
    end
  end

endmodule
